// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, constants and the fetch range check for imem_fetch_ctrl
package imem_pkg;

   localparam int WORD_W = 32;
   localparam int AW_DEF = 13;
   localparam logic [WORD_W-1:0] SENTINEL_DEF = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   // Word index is addr>>2; any byte address whose word index reaches the
   // loaded length (including addresses with high bits set) is out of range.
   function automatic logic word_in_range(input logic [WORD_W-1:0] addr,
                                          input logic [WORD_W-1:0] limit);
      logic [WORD_W-1:0] idx;
      idx = {2'b00, addr[WORD_W-1:2]};
      return (addr[1:0] == 2'b00) && (idx < limit);
   endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - loader, fetch and memory-port signals of imem_fetch_ctrl
interface imem_fetch_ctrl_if #(parameter int AW = imem_pkg::AW_DEF);

   logic                        ld_valid;
   logic                        ld_ready;
   logic [imem_pkg::WORD_W-1:0] ld_data;
   logic                        ld_last;

   logic                        fetch_req;
   logic [imem_pkg::WORD_W-1:0] fetch_addr;
   logic                        fetch_gnt;
   logic                        instr_valid;
   logic [imem_pkg::WORD_W-1:0] instr;
   logic                        fetch_err;
   logic                        halted;
   logic [AW:0]                 load_count;

   logic                        mem_en;
   logic                        mem_we;
   logic [AW-1:0]               mem_addr;
   logic [imem_pkg::WORD_W-1:0] mem_wdata;
   logic [imem_pkg::WORD_W-1:0] mem_rdata;

   modport master (
      input  ld_valid, ld_data, ld_last, fetch_req, fetch_addr, mem_rdata,
      output ld_ready, fetch_gnt, instr_valid, instr, fetch_err, halted, load_count,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output ld_valid, ld_data, ld_last, fetch_req, fetch_addr, mem_rdata,
      input  ld_ready, fetch_gnt, instr_valid, instr, fetch_err, halted, load_count,
             mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - program-load then fetch sequencer for the external instruction memory
// IMEM_HALT_DETECT_EN enables sentinel detection and the HALT state.
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter int AW = AW_DEF
`ifdef IMEM_HALT_DETECT_EN
 , parameter logic [WORD_W-1:0] SENTINEL = SENTINEL_DEF
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   imem_fetch_ctrl_if.master  bus
);

   state_t              state_q;
   state_t              state_d;
   logic [AW:0]         load_count_q;
   logic                rsp_valid_q;
   logic                rsp_err_q;
   logic [WORD_W-1:0]   instr_hold_q;
   logic [WORD_W-1:0]   instr_now;
   logic                fetch_ok;
   logic                ld_fire;
   logic                load_full;
   logic                sentinel_hit;

   assign fetch_ok  = word_in_range(bus.fetch_addr, {{(WORD_W-AW-1){1'b0}}, load_count_q});
   assign ld_fire   = bus.ld_valid & bus.ld_ready;
   assign load_full = (load_count_q[AW-1:0] == {AW{1'b1}});

   // Read data is passed straight through in the return cycle and captured
   // so instr keeps its value while instr_valid is low.
   assign instr_now = rsp_valid_q ? (rsp_err_q ? '0 : bus.mem_rdata) : instr_hold_q;

`ifdef IMEM_HALT_DETECT_EN
   assign sentinel_hit = rsp_valid_q & ~rsp_err_q & (bus.mem_rdata == SENTINEL);
   assign bus.halted   = (state_q == HALT);
`else
   assign sentinel_hit = 1'b0;
   assign bus.halted   = 1'b0;
`endif

   assign bus.instr_valid = rsp_valid_q;
   assign bus.instr       = instr_now;
   assign bus.fetch_err   = rsp_valid_q & rsp_err_q;
   assign bus.load_count  = load_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (ld_fire && (bus.ld_last || load_full)) state_d = RUN;
         RUN:     if (sentinel_hit) state_d = HALT;
         default: state_d = state_q;
      endcase
   end

   // Handshake and memory-port outputs are held at their idle values while
   // rst_n is low so the reset cycle itself presents a quiet interface.
   always_comb begin
      bus.ld_ready  = 1'b0;
      bus.fetch_gnt = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (rst_n) begin
         case (state_q)
            LOAD: begin
               bus.ld_ready = 1'b1;
               if (bus.ld_valid) begin
                  bus.mem_en    = 1'b1;
                  bus.mem_we    = 1'b1;
                  bus.mem_addr  = load_count_q[AW-1:0];
                  bus.mem_wdata = bus.ld_data;
               end
            end
            RUN: begin
               bus.fetch_gnt = bus.fetch_req;
               if (bus.fetch_req && fetch_ok) begin
                  bus.mem_en   = 1'b1;
                  bus.mem_addr = bus.fetch_addr[AW+1:2];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_count_q <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         instr_hold_q <= '0;
      end else begin
         if (ld_fire) begin
            load_count_q <= load_count_q + {{AW{1'b0}}, 1'b1};
         end
         rsp_valid_q <= bus.fetch_gnt;
         rsp_err_q   <= bus.fetch_gnt & ~fetch_ok;
         if (rsp_valid_q) begin
            instr_hold_q <= instr_now;
         end
      end
   end

endmodule
